// File: rtl/minimig_bank_responder.sv
// minimig_bank_responder
// Memory-side responder for the bank-select bus. A CPU request qualified by a
// one-hot bank select is turned into a physical word address on the 4 MB
// RAM/ROM store. The block then runs a req/ack handshake with the memory
// controller and returns read data and a one-cycle completion pulse.
//
// Ports
//   i_clk, i_reset_n         : clock, asynchronous active-low reset
//   i_cpu_req/we/addr/bank   : CPU request level, direction, word address, bank select
//   i_cpu_wdata, i_cpu_be    : write data and byte enables {upper, lower}
//   o_cpu_rdata, o_cpu_ack   : read data and one-cycle completion pulse
//   o_mem_req/we/addr/wdata/be : request to memory controller (held stable while pending)
//   i_mem_ack, i_mem_rdata   : completion and read data from memory controller
//   o_multi_hit, o_timeout   : sticky error flags, cleared only by reset
module minimig_bank_responder #(
  parameter int unsigned TIMEOUT = 255,
  parameter bit          KICK_WP = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [23:1] i_cpu_addr,
  input  logic [7:0]  i_cpu_bank,
  input  logic [15:0] i_cpu_wdata,
  input  logic [1:0]  i_cpu_be,
  output logic [15:0] o_cpu_rdata,
  output logic        o_cpu_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [21:1] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic [1:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic        o_multi_hit,
  output logic        o_timeout
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StRelease} state_e;

  state_e      r_state, w_state_d;
  logic [9:0]  r_cnt, w_cnt_d;
  logic        r_drop, w_drop_d;
  logic [15:0] r_cpu_rdata, w_cpu_rdata_d;
  logic        r_cpu_ack, w_cpu_ack_d;
  logic        r_mem_req, w_mem_req_d;
  logic        r_mem_we, w_mem_we_d;
  logic [21:1] r_mem_addr, w_mem_addr_d;
  logic [15:0] r_mem_wdata, w_mem_wdata_d;
  logic [1:0]  r_mem_be, w_mem_be_d;
  logic        r_multi_hit, w_multi_hit_d;
  logic        r_timeout, w_timeout_d;

  logic [2:0]  w_idx;
  logic        w_multi;
  logic        w_unused_addr;

  // Only a 256K-word window of the CPU address reaches the store.
  assign w_unused_addr = ^i_cpu_addr[23:19];

  // Highest set bank bit wins.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (i_cpu_bank[i]) w_idx = 3'(i);
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi = |(i_cpu_bank & (i_cpu_bank - 8'd1));

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_drop_d      = r_drop;
    w_cpu_rdata_d = r_cpu_rdata;
    w_cpu_ack_d   = 1'b0;
    w_mem_req_d   = r_mem_req;
    w_mem_we_d    = r_mem_we;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_mem_be_d    = r_mem_be;
    w_multi_hit_d = r_multi_hit;
    w_timeout_d   = r_timeout;

    unique case (r_state)
      StIdle: begin
        if (i_cpu_req && (i_cpu_bank != 8'd0)) begin
          w_mem_we_d    = i_cpu_we;
          w_mem_addr_d  = {w_idx, i_cpu_addr[18:1]};
          w_mem_wdata_d = i_cpu_wdata;
          w_mem_be_d    = i_cpu_be;
          w_drop_d      = KICK_WP && i_cpu_we && (w_idx[2:1] == 2'b11);
          if (w_multi) w_multi_hit_d = 1'b1;
          w_state_d     = StIssue;
        end
      end
      StIssue: begin
        // A dropped Kickstart write still spends this slot, so it acks one
        // cycle ahead of a zero-wait memory access, with no memory request.
        w_cnt_d = 10'd0;
        if (r_drop) begin
          w_state_d = StDone;
        end else begin
          w_mem_req_d = 1'b1;
          w_state_d   = StWait;
        end
      end
      StWait: begin
        // mem_ack takes precedence over a timeout expiring in the same cycle.
        if (i_mem_ack) begin
          if (!r_mem_we) w_cpu_rdata_d = i_mem_rdata;
          w_mem_req_d = 1'b0;
          w_state_d   = StDone;
        end else if (r_cnt == 10'(TIMEOUT - 1)) begin
          w_mem_req_d   = 1'b0;
          w_cpu_rdata_d = 16'hFFFF;
          w_timeout_d   = 1'b1;
          w_state_d     = StDone;
        end else begin
          w_cnt_d = r_cnt + 10'd1;
        end
      end
      StDone: begin
        w_cpu_ack_d = 1'b1;
        w_state_d   = StRelease;
      end
      StRelease: begin
        // A held request must drop before another access is accepted.
        if (!i_cpu_req) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_cnt       <= 10'd0;
      r_drop      <= 1'b0;
      r_cpu_rdata <= 16'd0;
      r_cpu_ack   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 21'd0;
      r_mem_wdata <= 16'd0;
      r_mem_be    <= 2'd0;
      r_multi_hit <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_drop      <= w_drop_d;
      r_cpu_rdata <= w_cpu_rdata_d;
      r_cpu_ack   <= w_cpu_ack_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_mem_be    <= w_mem_be_d;
      r_multi_hit <= w_multi_hit_d;
      r_timeout   <= w_timeout_d;
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_multi_hit = r_multi_hit;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_minimig_bank_responder.sv
// Scoreboard bench for minimig_bank_responder. The stimulus process pushes
// expected CPU read data and expected memory requests; a monitor pops and
// compares whenever cpu_ack pulses or mem_req rises.
module tb_minimig_bank_responder;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_cpu_req, req2, i_cpu_we;
  logic [23:1] i_cpu_addr;
  logic [7:0]  i_cpu_bank;
  logic [15:0] i_cpu_wdata;
  logic [1:0]  i_cpu_be;
  logic [15:0] o_cpu_rdata, o_cpu_rdata2;
  logic        o_cpu_ack, o_cpu_ack2;
  logic        o_mem_req, o_mem_req2, o_mem_we, o_mem_we2;
  logic [21:1] o_mem_addr, o_mem_addr2;
  logic [15:0] o_mem_wdata, o_mem_wdata2;
  logic [1:0]  o_mem_be, o_mem_be2;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
  logic        o_multi_hit, o_multi_hit2, o_timeout, o_timeout2;

  typedef struct {
    logic [20:0] addr;
    logic        we;
    logic [1:0]  be;
    logic [15:0] wdata;
  } mem_exp_t;

  logic [15:0] exp_q[$];
  mem_exp_t    mem_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_cnt = 0, last_ack_cyc = 0, mem_rises = 0, req_len = 0, last_req_len = 0;
  int mem_delay = -1;
  logic [15:0] mem_rd = 16'd0;
  int late_tok = 0, late_seen = 0, wcnt = 0;
  logic [15:0] model_rdata = 16'd0;
  int req_cyc = 0;

  minimig_bank_responder #(.TIMEOUT(16), .KICK_WP(1'b1)) u_dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we),
    .i_cpu_addr(i_cpu_addr), .i_cpu_bank(i_cpu_bank), .i_cpu_wdata(i_cpu_wdata),
    .i_cpu_be(i_cpu_be), .o_cpu_rdata(o_cpu_rdata), .o_cpu_ack(o_cpu_ack),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_multi_hit(o_multi_hit), .o_timeout(o_timeout)
  );

  // Second instance with Kickstart write protection disabled; its memory
  // never acks, so any access it makes ends by timeout.
  minimig_bank_responder #(.TIMEOUT(16), .KICK_WP(1'b0)) u_dut_nowp (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_cpu_req(req2), .i_cpu_we(i_cpu_we),
    .i_cpu_addr(i_cpu_addr), .i_cpu_bank(i_cpu_bank), .i_cpu_wdata(i_cpu_wdata),
    .i_cpu_be(i_cpu_be), .o_cpu_rdata(o_cpu_rdata2), .o_cpu_ack(o_cpu_ack2),
    .o_mem_req(o_mem_req2), .o_mem_we(o_mem_we2), .o_mem_addr(o_mem_addr2),
    .o_mem_wdata(o_mem_wdata2), .o_mem_be(o_mem_be2), .i_mem_ack(1'b0),
    .i_mem_rdata(i_mem_rdata), .o_multi_hit(o_multi_hit2), .o_timeout(o_timeout2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory controller model: acks mem_delay cycles into a request (-1 = never),
  // and emits one stray ack whenever late_tok is bumped.
  initial begin
    i_mem_ack = 1'b0;
    i_mem_rdata = 16'd0;
    forever begin
      @(posedge clk);
      #1;
      i_mem_ack = 1'b0;
      if (late_tok != late_seen) begin
        late_seen = late_tok;
        i_mem_ack = 1'b1;
        i_mem_rdata = 16'h0BAD;
      end else if (o_mem_req && mem_delay >= 0) begin
        if (wcnt == mem_delay) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = mem_rd;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_req;
    mem_exp_t m;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (o_cpu_ack) begin
        ack_cnt++;
        last_ack_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_cpu_ack", 32'(o_cpu_rdata), 32'hFFFF_FFFF);
        end else begin
          chk("cpu_rdata", 32'(o_cpu_rdata), 32'(exp_q.pop_front()));
        end
      end
      if (o_mem_req && !prev_req) begin
        mem_rises++;
        req_len = 0;
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 32'(o_mem_addr), 32'hFFFF_FFFF);
        end else begin
          m = mem_q.pop_front();
          chk("mem_addr", 32'(o_mem_addr), 32'(m.addr));
          chk("mem_we", 32'(o_mem_we), 32'(m.we));
          chk("mem_be", 32'(o_mem_be), 32'(m.be));
          chk("mem_wdata", 32'(o_mem_wdata), 32'(m.wdata));
        end
      end
      if (o_mem_req) req_len++;
      if (!o_mem_req && prev_req) last_req_len = req_len;
      prev_req = o_mem_req;
    end
  end

  task automatic drive(input logic we, input logic [7:0] bank, input logic [17:0] a,
                       input logic [15:0] wd, input logic [1:0] be);
    i_cpu_we    = we;
    i_cpu_bank  = bank;
    i_cpu_addr  = {5'b10101, a};
    i_cpu_wdata = wd;
    i_cpu_be    = be;
  endtask

  task automatic do_access(input string nm, input logic we, input logic [7:0] bank,
                           input logic [17:0] a, input logic [15:0] wd, input logic [1:0] be,
                           input int delay, input logic [15:0] rd, input bit exp_mem,
                           input logic [20:0] exp_addr, input int exp_lat, input int hold);
    int start_ack;
    int start_rise;
    bit got;
    start_ack = ack_cnt;
    start_rise = mem_rises;
    got = 1'b0;
    mem_delay = delay;
    mem_rd = rd;
    if (exp_mem) mem_q.push_back('{addr: exp_addr, we: we, be: be, wdata: wd});
    if (!we) model_rdata = (delay < 0) ? 16'hFFFF : rd;
    exp_q.push_back(model_rdata);
    @(posedge clk);
    #1;
    drive(we, bank, a, wd, be);
    i_cpu_req = 1'b1;
    req_cyc = cyc + 1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      #1;
      if (ack_cnt != start_ack) got = 1'b1;
    end
    if (!got) chk({nm, "_ack_seen"}, 0, 1);
    else chk({nm, "_ack_latency"}, 32'(last_ack_cyc - req_cyc), 32'(exp_lat));
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    i_cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "_ack_count"}, 32'(ack_cnt - start_ack), 32'd1);
    chk({nm, "_mem_cycles"}, 32'(mem_rises - start_rise), 32'(exp_mem));
  endtask

  initial begin
    int s_ack;
    int s_rise;
    bit got;
    i_reset_n = 1'b0;
    i_cpu_req = 1'b0;
    req2 = 1'b0;
    drive(1'b0, 8'd0, 18'd0, 16'd0, 2'd0);
    #12;
    chk("rst_cpu_rdata", 32'(o_cpu_rdata), 0);
    chk("rst_cpu_ack", 32'(o_cpu_ack), 0);
    chk("rst_mem_req", 32'(o_mem_req), 0);
    chk("rst_mem_we", 32'(o_mem_we), 0);
    chk("rst_mem_addr", 32'(o_mem_addr), 0);
    chk("rst_mem_wdata", 32'(o_mem_wdata), 0);
    chk("rst_mem_be", 32'(o_mem_be), 0);
    chk("rst_multi_hit", 32'(o_multi_hit), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    @(negedge clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reads: bank 2 with 2-cycle wait, bank 0 zero-wait at top of window.
    do_access("rd_b2", 1'b0, 8'h04, 18'h01234, 16'h0000, 2'b11, 2, 16'hBEEF, 1'b1,
              21'h081234, 5, 0);
    do_access("rd_b0", 1'b0, 8'h01, 18'h3FFFF, 16'h0000, 2'b11, 0, 16'h1234, 1'b1,
              21'h03FFFF, 3, 0);
    // Kickstart write dropped; read data unchanged.
    do_access("kick_wr", 1'b1, 8'h80, 18'h00010, 16'hA5A5, 2'b10, 0, 16'h0000, 1'b0,
              21'h0, 2, 0);
    // Ordinary write to bank 1.
    do_access("wr_b1", 1'b1, 8'h02, 18'h00ABC, 16'h5A5A, 2'b01, 0, 16'h0000, 1'b1,
              21'h040ABC, 3, 0);
    chk("multi_hit_clear", 32'(o_multi_hit), 0);

    // Same Kickstart write with protection off reaches memory.
    @(posedge clk);
    #1;
    drive(1'b1, 8'h80, 18'h00010, 16'hA5A5, 2'b10);
    req2 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (o_mem_req2) got = 1'b1;
    end
    chk("nowp_mem_req", 32'(got), 1);
    chk("nowp_mem_bank", 32'(o_mem_addr2[21:19]), 7);
    chk("nowp_mem_addr", 32'(o_mem_addr2), 32'h1C0010);
    chk("nowp_mem_we", 32'(o_mem_we2), 1);
    chk("nowp_mem_be", 32'(o_mem_be2), 32'h2);
    chk("nowp_mem_wdata", 32'(o_mem_wdata2), 32'hA5A5);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (o_cpu_ack2) got = 1'b1;
    end
    chk("nowp_cpu_ack", 32'(got), 1);
    @(posedge clk);
    #1;
    req2 = 1'b0;

    // Two banks selected: index 4 wins, sticky multi_hit.
    do_access("multi", 1'b0, 8'h11, 18'h00100, 16'h0000, 2'b11, 1, 16'hCAFE, 1'b1,
              21'h100100, 4, 0);
    chk("multi_hit_set", 32'(o_multi_hit), 1);
    do_access("after_multi", 1'b0, 8'h08, 18'h00777, 16'h0000, 2'b11, 0, 16'h4321, 1'b1,
              21'h0C0777, 3, 0);
    chk("multi_hit_sticky", 32'(o_multi_hit), 1);

    // Timeout: memory never acks.
    chk("timeout_clear", 32'(o_timeout), 0);
    do_access("tmo", 1'b0, 8'h20, 18'h00005, 16'h0000, 2'b11, -1, 16'h0000, 1'b1,
              21'h140005, 18, 0);
    chk("tmo_req_len", 32'(last_req_len), 16);
    chk("tmo_flag", 32'(o_timeout), 1);
    s_ack = ack_cnt;
    late_tok++;
    repeat (6) @(negedge clk);
    #1;
    chk("late_ack_ignored", 32'(ack_cnt - s_ack), 0);
    chk("late_ack_rdata", 32'(o_cpu_rdata), 32'hFFFF);

    // Held request is serviced once.
    do_access("held", 1'b0, 8'h04, 18'h00042, 16'h0000, 2'b01, 0, 16'h1111, 1'b1,
              21'h080042, 3, 10);

    // Bank select of zero is not for this block.
    s_ack = ack_cnt;
    s_rise = mem_rises;
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 18'h00042, 16'h0000, 2'b11);
    i_cpu_req = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("bank0_no_ack", 32'(ack_cnt - s_ack), 0);
    chk("bank0_no_mem", 32'(mem_rises - s_rise), 0);
    @(posedge clk);
    #1;
    i_cpu_req = 1'b0;

    // Reset asserted while waiting on memory.
    mem_delay = -1;
    mem_q.push_back('{addr: 21'h0C0777, we: 1'b0, be: 2'b11, wdata: 16'h0000});
    @(posedge clk);
    #1;
    drive(1'b0, 8'h08, 18'h00777, 16'h0000, 2'b11);
    i_cpu_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_rst_mem_req", 32'(o_mem_req), 1);
    @(posedge clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(o_mem_req), 0);
    chk("rst_mid_cpu_rdata", 32'(o_cpu_rdata), 0);
    chk("rst_mid_mem_addr", 32'(o_mem_addr), 0);
    chk("rst_mid_multi_hit", 32'(o_multi_hit), 0);
    chk("rst_mid_timeout", 32'(o_timeout), 0);
    i_cpu_req = 1'b0;
    model_rdata = 16'd0;
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    do_access("post_rst", 1'b0, 8'h40, 18'h2AAAA, 16'h0000, 2'b11, 1, 16'h7E57, 1'b1,
              21'h1AAAAA, 4, 0);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("mem_q_drained", 32'(mem_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
